// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory port arbiter.
// The struct widths come from MEM_ADDR_W/MEM_DATA_W here. The arbiter's
// ADDR_W/DATA_W parameters default to these values, so change both together.
package riscv_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  localparam logic [MEM_BE_W-1:0] BE_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between the fetch (IF) and load/store (D) ports.
// D has fixed priority. IF is forced through once it has lost STARVE_MAX
// consecutive D grants while it was requesting.
module arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_d
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // Pick rule: IF wins when D is absent or IF has hit the starvation bound.
  always_comb begin
    starved  = (starve_cnt == CNT_MAX);
    grant_if = grant_en & if_req & (~d_req | starved);
    grant_d  = grant_en & d_req & ~grant_if;
  end

  // Count the D grants that IF lost. The count saturates and clears on any IF grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the IF and D pipeline ports.
// Requests are latched into the mem_* registers, and the memory handshake
// runs to mem_ack. Read data is returned unregistered with a one-cycle valid.
// Optional macro ARB_BACK2BACK_EN: on an ack, hand the memory straight to the
// other waiting requester without passing through IDLE.
//
// state   | meaning
// IDLE    | no transfer in flight, arbitrating incoming requests
// BUSY_IF | fetch transfer in flight, waiting for mem_ack
// BUSY_D  | load/store transfer in flight, waiting for mem_ack
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  arb_state_t state, state_next;
  mem_cmd_t   cmd, cmd_next;
  logic       mem_req_next;
  logic       grant_en, grant_if, grant_d;
  logic       pick_if_req, pick_d_req;
  logic       ack_if, ack_d;

  // An ack only counts while a transfer is in flight. A stray ack in IDLE is ignored.
  assign ack_if = (state == BUSY_IF) & mem_ack;
  assign ack_d  = (state == BUSY_D) & mem_ack;

  // A requester that dropped mid-transfer gets no completion pulse.
  assign if_valid  = ack_if & if_req;
  assign d_valid   = ack_d & d_req;
  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req & ~d_valid;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign mem_be    = cmd.be;

  // Arbitrate in IDLE. With back-to-back enabled, also arbitrate in an ack
  // cycle, offering the memory only to the port that was not just served.
  always_comb begin
    grant_en    = (state == IDLE);
    pick_if_req = if_req;
    pick_d_req  = d_req;
`ifdef ARB_BACK2BACK_EN
    if (ack_if) begin
      grant_en    = 1'b1;
      pick_if_req = 1'b0;
    end
    if (ack_d) begin
      grant_en   = 1'b1;
      pick_d_req = 1'b0;
    end
`endif
  end

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .if_req   (pick_if_req),
    .d_req    (pick_d_req),
    .grant_en (grant_en),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Next state and next latched command. A grant overrides the return to IDLE.
  always_comb begin
    state_next   = state;
    cmd_next     = cmd;
    mem_req_next = mem_req;
    case (state)
      BUSY_IF, BUSY_D: begin
        if (mem_ack) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
        end
      end
      default: ;
    endcase
    if (grant_if) begin
      state_next     = BUSY_IF;
      mem_req_next   = 1'b1;
      cmd_next.we    = 1'b0;
      cmd_next.addr  = if_addr;
      cmd_next.wdata = '0;
      cmd_next.be    = BE_ALL_ONES;
    end else if (grant_d) begin
      state_next     = BUSY_D;
      mem_req_next   = 1'b1;
      cmd_next.we    = d_we;
      cmd_next.addr  = d_addr;
      cmd_next.wdata = d_wdata;
      cmd_next.be    = d_be;
    end
  end

  // State and memory-side registers. Reset abandons any in-flight transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cmd     <= '0;
      mem_req <= 1'b0;
    end else begin
      state   <= state_next;
      cmd     <= cmd_next;
      mem_req <= mem_req_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a two-cycle memory responder.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

`ifdef ARB_BACK2BACK_EN
  localparam int    EXP_STARVE_ND = 1;
  localparam int    EXP_GAP_LOW   = 0;
  localparam string EXP_GAP_ORDER = "DIDI";
`else
  localparam int    EXP_STARVE_ND = 4;
  localparam int    EXP_GAP_LOW   = 3;
  localparam string EXP_GAP_ORDER = "DDDD";
`endif

  logic          clk, reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid, if_stall;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_valid, d_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_arr [0:15];
  bit          mem_en = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  int          mem_cnt = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks in the second cycle mem_req is seen high, one-cycle ack.
  // When disabled, mem_ack/mem_rdata follow man_ack/man_rdata.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_en) begin
        mem_cnt = 0;
        mem_ack = man_ack;
        mem_rdata = man_rdata;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          mem_cnt = 0;
        end
        if (mem_req) begin
          mem_cnt++;
          if (mem_cnt == 2) begin
            mem_ack = 1'b1;
            mem_rdata = mem_arr[mem_addr[5:2]];
            if (mem_we)
              for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_arr[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
        end else begin
          mem_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output bit idle);
    idle = 1'b0;
    for (int c = 0; c < 20 && !idle; c++) begin
      @(negedge clk);
      if (mem_req === 1'b0) idle = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1;
    step(); step();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); end
    checks++; if (mem_be !== '0) begin errors++; $display("FAIL reset_mem_be: got %b want 0000", mem_be); end
    checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got if=%b d=%b want 0/0", if_valid, d_valid); end
    checks++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got if=%b d=%b want 1/1", if_stall, d_stall); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    step();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_if_only();
    int rise = -1, vcyc = -1, stall_hi = 0, extra = 0;
    logic stall_at_v = 1'bx;
    logic [31:0] rd = '0;
    step();
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 0; c < 20 && vcyc < 0; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && rise < 0) rise = c;
      if (if_valid === 1'b1) begin vcyc = c; rd = if_rdata; stall_at_v = if_stall; end
      else if (if_stall === 1'b1) stall_hi++;
    end
    step();
    if_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_valid === 1'b1) extra++;
    end
    checks++; if (rise != 1) begin errors++; $display("FAIL if_only_req_latency: got %0d want 1", rise); end
    checks++; if (vcyc != 2) begin errors++; $display("FAIL if_only_valid_cycle: got %0d want 2", vcyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL if_only_rdata: got %h want deadbeef", rd); end
    checks++; if (stall_hi != 2 || stall_at_v !== 1'b0) begin errors++; $display("FAIL if_only_stall: got hi=%0d at_valid=%b want 2/0", stall_hi, stall_at_v); end
    checks++; if (extra != 0 || mem_req !== 1'b0) begin errors++; $display("FAIL if_only_single_pulse: got extra=%0d mem_req=%b want 0/0", extra, mem_req); end
  endtask

  task automatic test_priority();
    int vcyc = -1, if_low = 0, if_early = 0;
    bit got_if = 1'b0;
    logic [31:0] rd = '0, rd2 = '0;
    step();
    if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
    for (int c = 0; c < 20 && vcyc < 0; c++) begin
      @(negedge clk);
      if (if_valid === 1'b1) if_early++;
      if (if_stall !== 1'b1) if_low++;
      if (d_valid === 1'b1) begin vcyc = c; rd = d_rdata; end
    end
    step();
    d_req = 1'b0;
    for (int c = 0; c < 20 && !got_if; c++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin got_if = 1'b1; rd2 = if_rdata; end
    end
    checks++; if (vcyc != 2 || if_early != 0) begin errors++; $display("FAIL prio_d_first: got d_cycle=%0d if_pulses=%0d want 2/0", vcyc, if_early); end
    checks++; if (rd !== 32'hFEDCBA98) begin errors++; $display("FAIL prio_d_rdata: got %h want fedcba98", rd); end
    checks++; if (if_low != 0) begin errors++; $display("FAIL prio_if_stall: got %0d low cycles want 0", if_low); end
    checks++; if (!got_if || rd2 !== 32'h12345678) begin errors++; $display("FAIL prio_if_rdata: got seen=%b %h want 1 12345678", got_if, rd2); end
    checks++; if (dut.u_pick.starve_cnt !== '0) begin errors++; $display("FAIL prio_starve_cnt: got %0d want 0", dut.u_pick.starve_cnt); end
    step();
    if_req = 1'b0;
  endtask

  task automatic test_starve();
    logic [31:0] exp_rd [4] = '{32'hDEADBEEF, 32'h12345678, 32'hAAAAAAAA, 32'hFEDCBA98};
    int nd = 0;
    bit got_if = 1'b0, idle;
    step();
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    for (int c = 0; c < 100 && !got_if; c++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        got_if = 1'b1;
      end else if (d_valid === 1'b1) begin
        checks++;
        if (d_rdata !== exp_rd[nd % 4]) begin errors++; $display("FAIL starve_d_rdata%0d: got %h want %h", nd, d_rdata, exp_rd[nd % 4]); end
        nd++;
        step();
        d_addr = 32'((nd % 4) * 4);
      end
    end
    step();
    if_req = 1'b0; d_req = 1'b0;
    wait_idle(idle);
    checks++; if (!got_if || nd != EXP_STARVE_ND) begin errors++; $display("FAIL starve_d_grants: got if_seen=%b d_count=%0d want 1/%0d", got_if, nd, EXP_STARVE_ND); end
    checks++; if (dut.u_pick.starve_cnt !== '0) begin errors++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.u_pick.starve_cnt); end
    checks++; if (!idle) begin errors++; $display("FAIL starve_drain: got mem_req=%b want 0", mem_req); end
  endtask

  task automatic test_store();
    int vcyc = -1, rcyc = 0, bad = 0, webad = 0;
    bit idle;
    logic [31:0] rd = '0;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h00000004; d_be = 4'b0011;
    for (int c = 0; c < 20 && vcyc < 0; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        rcyc++;
        if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h8 || mem_wdata !== 32'h4) bad++;
      end
      if (d_valid === 1'b1) vcyc = c;
    end
    checks++; if (vcyc != 2 || rcyc != 2) begin errors++; $display("FAIL store_timing: got valid=%0d req_cycles=%0d want 2/2", vcyc, rcyc); end
    checks++; if (bad != 0) begin errors++; $display("FAIL store_fields_held: got %0d bad cycles want 0", bad); end
    step();
    d_we = 1'b0;
    vcyc = -1;
    for (int c = 0; c < 20 && vcyc < 0; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we !== 1'b0) webad++;
      if (d_valid === 1'b1) begin vcyc = c; rd = d_rdata; end
    end
    step();
    d_req = 1'b0;
    wait_idle(idle);
    checks++; if (vcyc != 2 || webad != 0) begin errors++; $display("FAIL store_followup_load: got valid=%0d we_bad=%0d want 2/0", vcyc, webad); end
    checks++; if (rd !== 32'hAAAA0004) begin errors++; $display("FAIL store_readback: got %h want aaaa0004", rd); end
    checks++; if (!idle) begin errors++; $display("FAIL store_drain: got mem_req=%b want 0", mem_req); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_en = 1'b0; man_ack = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || dut.state !== BUSY_D) begin errors++; $display("FAIL rmid_busy: got mem_req=%b state=%0d want 1/BUSY_D", mem_req, dut.state); end
    step();
    reset = 1'b0; d_req = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || dut.state !== IDLE) begin errors++; $display("FAIL rmid_abandon: got mem_req=%b state=%0d want 0/IDLE", mem_req, dut.state); end
    man_ack = 1'b1; man_rdata = 32'hFEDCBA98;
    @(negedge clk);
    checks++; if (d_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_stray_valid: got d=%b if=%b want 0/0", d_valid, if_valid); end
    man_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || dut.state !== IDLE) begin errors++; $display("FAIL rmid_stray_state: got mem_req=%b state=%0d want 0/IDLE", mem_req, dut.state); end
    mem_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int nval = 0, low = 0;
    bit started = 1'b0, idle;
    string order = "";
    step();
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    for (int c = 0; c < 60 && nval < 4; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) started = 1'b1;
      else if (started) low++;
      if (d_valid === 1'b1) begin order = {order, "D"}; nval++; end
      if (if_valid === 1'b1) begin order = {order, "I"}; nval++; end
    end
    step();
    if_req = 1'b0; d_req = 1'b0;
    wait_idle(idle);
    checks++; if (order != EXP_GAP_ORDER) begin errors++; $display("FAIL b2b_order: got %s want %s", order, EXP_GAP_ORDER); end
    checks++; if (low != EXP_GAP_LOW) begin errors++; $display("FAIL b2b_gap_cycles: got %0d want %0d", low, EXP_GAP_LOW); end
    checks++; if (!idle) begin errors++; $display("FAIL b2b_drain: got mem_req=%b want 0", mem_req); end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '1;
    for (int i = 0; i < 16; i++) mem_arr[i] = '0;
    mem_arr[0] = 32'hDEADBEEF;
    mem_arr[1] = 32'h12345678;
    mem_arr[2] = 32'hAAAAAAAA;
    mem_arr[3] = 32'hFEDCBA98;
    test_reset();
    test_if_only();
    test_priority();
    test_starve();
    test_store();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
